// File: rtl/uart_cmd_decoder.sv
// Host command frame decoder. Parses 4-byte frames (A5, CMD, ARG, CSUM) from the
// UART receive path and drives the trace configuration registers and status outputs.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 480000,
  parameter logic [2:0]  DEFAULT_WIDTH  = 3'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       recv_error,
  output logic [2:0] width,
  output logic       trace_en,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StArg, StCsum} state_e;

  state_e          state;
  logic [7:0]      cmdByte;
  logic [7:0]      argByte;
  logic [CntW-1:0] timeoutCnt;
  logic            cmdValid;
  logic            execOk;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame verdict for the byte currently on rx_byte, used only in the CSUM state.
  always_comb begin
    cmdValid = 1'b0;
    case (cmdByte)
      8'h01:   cmdValid = (argByte == 8'd1) || (argByte == 8'd2) || (argByte == 8'd4);
      8'h02:   cmdValid = (argByte == 8'd0) || (argByte == 8'd1);
      8'h03:   cmdValid = 1'b1;
      default: cmdValid = 1'b0;
    endcase
    execOk = cmdValid && (rx_byte == (cmdByte ^ argByte));
  end

  // Parser FSM with registered config, status pulses, error counter and timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      cmdByte    <= 8'h00;
      argByte    <= 8'h00;
      timeoutCnt <= '0;
      width      <= DEFAULT_WIDTH;
      trace_en   <= 1'b0;
      cmd_ok     <= 1'b0;
      cmd_err    <= 1'b0;
      err_count  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      if (state == StIdle) begin
        timeoutCnt <= '0;
        // Non-header bytes and framing errors are dropped silently while idle.
        if (received && !recv_error && rx_byte == 8'hA5) begin
          state <= StCmd;
          busy  <= 1'b1;
        end
      end else if (recv_error) begin
        state      <= StIdle;
        busy       <= 1'b0;
        timeoutCnt <= '0;
        cmd_err    <= 1'b1;
        err_count  <= satInc(err_count);
      end else if (received) begin
        // A byte on the expiry cycle takes priority over the timeout.
        timeoutCnt <= '0;
        unique case (state)
          StCmd: begin
            cmdByte <= rx_byte;
            state   <= StArg;
          end
          StArg: begin
            argByte <= rx_byte;
            state   <= StCsum;
          end
          StCsum: begin
            state <= StIdle;
            busy  <= 1'b0;
            if (execOk) begin
              cmd_ok <= 1'b1;
              case (cmdByte)
                8'h01:   width     <= argByte[2:0];
                8'h02:   trace_en  <= argByte[0];
                8'h03:   err_count <= 8'h00;
                default: ;
              endcase
            end else begin
              cmd_err   <= 1'b1;
              err_count <= satInc(err_count);
            end
          end
          default: state <= StIdle;
        endcase
      end else if (timeoutCnt == CntLast) begin
        state      <= StIdle;
        busy       <= 1'b0;
        timeoutCnt <= '0;
        cmd_err    <= 1'b1;
        err_count  <= satInc(err_count);
      end else begin
        timeoutCnt <= timeoutCnt + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios followed by random
// frames, all compared every cycle against a queue-based frame model.
module tb_uart_cmd_decoder;

  localparam int unsigned Tmo = 20;

  logic       clk;
  logic       rst;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic [2:0] width;
  logic       trace_en;
  logic       cmd_ok;
  logic       cmd_err;
  logic [7:0] err_count;
  logic       busy;

  uart_cmd_decoder #(
    .TIMEOUT_CYCLES(Tmo),
    .DEFAULT_WIDTH (3'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .received  (received),
    .rx_byte   (rx_byte),
    .recv_error(recv_error),
    .width     (width),
    .trace_en  (trace_en),
    .cmd_ok    (cmd_ok),
    .cmd_err   (cmd_err),
    .err_count (err_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes of the frame in progress plus idle-cycle gap.
  logic [7:0] frameQ[$];
  int         gap;
  int         mWidth;
  int         mEn;
  int         mOk;
  int         mErr;
  int         mCnt;

  task automatic checkVal(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    frameQ.delete();
    gap    = 0;
    mWidth = 4;
    mEn    = 0;
    mOk    = 0;
    mErr   = 0;
    mCnt   = 0;
  endtask

  task automatic modelFail();
    mErr = 1;
    if (mCnt < 255) mCnt++;
  endtask

  task automatic modelExec(input int c, input int a, input int s);
    if ((c ^ a) != s) modelFail();
    else if (c == 1 && (a == 1 || a == 2 || a == 4)) begin mWidth = a; mOk = 1; end
    else if (c == 2 && a <= 1) begin mEn = a; mOk = 1; end
    else if (c == 3) begin mCnt = 0; mOk = 1; end
    else modelFail();
  endtask

  task automatic modelStep(input logic rcv, input logic [7:0] b, input logic rerr);
    mOk  = 0;
    mErr = 0;
    if (frameQ.size() == 0) begin
      gap = 0;
      if (rcv && !rerr && b == 8'hA5) frameQ.push_back(b);
    end else if (rerr) begin
      frameQ.delete();
      modelFail();
    end else if (rcv) begin
      frameQ.push_back(b);
      gap = 0;
      if (frameQ.size() == 4) begin
        modelExec(int'(frameQ[1]), int'(frameQ[2]), int'(frameQ[3]));
        frameQ.delete();
      end
    end else if (gap == int'(Tmo) - 1) begin
      frameQ.delete();
      gap = 0;
      modelFail();
    end else begin
      gap++;
    end
  endtask

  task automatic checkAll();
    checkVal("width", int'(width), mWidth);
    checkVal("trace_en", int'(trace_en), mEn);
    checkVal("cmd_ok", int'(cmd_ok), mOk);
    checkVal("cmd_err", int'(cmd_err), mErr);
    checkVal("err_count", int'(err_count), mCnt);
    checkVal("busy", int'(busy), (frameQ.size() != 0) ? 1 : 0);
  endtask

  // Entered and left at posedge+1: drive, clock, update model, sample.
  task automatic doCycle(input logic rcv, input logic [7:0] b, input logic rerr);
    received   = rcv;
    rx_byte    = b;
    recv_error = rerr;
    @(posedge clk);
    modelStep(rcv, b, rerr);
    #1;
    received   = 1'b0;
    recv_error = 1'b0;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) doCycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic sendFrame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    doCycle(1'b1, 8'hA5, 1'b0);
    doCycle(1'b1, c, 1'b0);
    doCycle(1'b1, a, 1'b0);
    doCycle(1'b1, s, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c;
    logic [7:0] a;
    logic [7:0] s;
    logic [7:0] bytes[4];
    rst        = 1'b0;
    received   = 1'b0;
    rx_byte    = 8'h00;
    recv_error = 1'b0;
    modelReset();

    // Reset values while held.
    #12;
    checkAll();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAll();

    // 1: set width 2.
    sendFrame(8'h01, 8'h02, 8'h03);
    checkVal("t1 width", int'(width), 2);
    checkVal("t1 errcnt", int'(err_count), 0);
    idle(1);
    checkVal("t1 ok single", int'(cmd_ok), 0);

    // 2: illegal width arg, then enable.
    sendFrame(8'h01, 8'h03, 8'h02);
    checkVal("t2 err", int'(cmd_err), 1);
    checkVal("t2 width", int'(width), 2);
    checkVal("t2 errcnt", int'(err_count), 1);
    sendFrame(8'h02, 8'h01, 8'h03);
    checkVal("t2 en", int'(trace_en), 1);
    checkVal("t2 ok", int'(cmd_ok), 1);

    // 3: bad checksums saturate the counter, clear resets it.
    for (int i = 0; i < 300; i++) sendFrame(8'h01, 8'h04, 8'h00);
    checkVal("t3 sat", int'(err_count), 255);
    checkVal("t3 width", int'(width), 2);
    sendFrame(8'h03, 8'h00, 8'h03);
    checkVal("t3 clr", int'(err_count), 0);
    checkVal("t3 ok", int'(cmd_ok), 1);

    // 4: timeout, then a byte exactly on the expiry cycle.
    doCycle(1'b1, 8'hA5, 1'b0);
    doCycle(1'b1, 8'h01, 1'b0);
    idle(int'(Tmo) - 1);
    checkVal("t4 busy pre", int'(busy), 1);
    idle(1);
    checkVal("t4 tmo err", int'(cmd_err), 1);
    checkVal("t4 busy", int'(busy), 0);
    doCycle(1'b1, 8'hA5, 1'b0);
    doCycle(1'b1, 8'h01, 1'b0);
    idle(int'(Tmo) - 1);
    doCycle(1'b1, 8'h01, 1'b0);
    checkVal("t4 race err", int'(cmd_err), 0);
    checkVal("t4 race busy", int'(busy), 1);
    doCycle(1'b1, 8'h00, 1'b0);
    checkVal("t4 width", int'(width), 1);

    // 5: framing error aborts, then junk is ignored.
    doCycle(1'b1, 8'hA5, 1'b0);
    doCycle(1'b1, 8'h01, 1'b0);
    doCycle(1'b1, 8'h02, 1'b1);
    checkVal("t5 err", int'(cmd_err), 1);
    checkVal("t5 busy", int'(busy), 0);
    doCycle(1'b1, 8'h00, 1'b0);
    doCycle(1'b1, 8'hFF, 1'b0);
    checkVal("t5 junk err", int'(cmd_err), 0);
    checkVal("t5 junk busy", int'(busy), 0);

    // 6: asynchronous reset mid-frame.
    sendFrame(8'h02, 8'h01, 8'h03);
    doCycle(1'b1, 8'hA5, 1'b0);
    doCycle(1'b1, 8'h02, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkVal("t6 en", int'(trace_en), 0);
    checkVal("t6 width", int'(width), 4);
    checkVal("t6 busy", int'(busy), 0);
    checkVal("t6 errcnt", int'(err_count), 0);
    modelReset();
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAll();
    sendFrame(8'h01, 8'h01, 8'h00);
    checkVal("t6 resume", int'(width), 1);

    // Random frames with gaps, bad fields and occasional framing errors.
    for (int f = 0; f < 400; f++) begin
      c = 8'($urandom_range(0, 4));
      case ($urandom_range(0, 5))
        0: a = 8'd0;
        1: a = 8'd1;
        2: a = 8'd2;
        3: a = 8'd4;
        4: a = 8'd3;
        default: a = 8'($urandom);
      endcase
      s = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (c ^ a);
      bytes[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hA5;
      bytes[1] = c;
      bytes[2] = a;
      bytes[3] = s;
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 15))
          0:       idle(int'(Tmo) - 1 + int'($urandom_range(0, 2)));
          1, 2:    idle(int'($urandom_range(1, 3)));
          default: ;
        endcase
        doCycle(1'b1, bytes[k], ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
      end
    end
    idle(int'(Tmo) + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
